// File: rtl/encoder_input_conditioner_pkg.sv
// Shared constants and types for the KY-040 encoder input conditioner.
package encoder_pkg;

  localparam logic ENC_PIN_IDLE = 1'b1;

  localparam int ENC_DEBOUNCE_CYCLES_DEFAULT = 50_000;

  // "release" is a reserved word in SystemVerilog, hence release_ev.
  typedef struct packed {
    logic press;
    logic release_ev;
    logic long_press;
  } enc_btn_evt_t;

endpackage

// File: rtl/encoder_input_conditioner_if.sv
// Pin-side bundle of the encoder conditioner: raw board pins in, clean levels and button events out.
interface encoder_input_conditioner_if;

  logic a_raw;
  logic b_raw;
  logic sw_raw;
  logic a_clean;
  logic b_clean;
  logic btn_pressed;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  // Board / stimulus side: drives the raw pins, observes the conditioned outputs.
  modport master (
    output a_raw, b_raw, sw_raw,
    input  a_clean, b_clean, btn_pressed, btn_press, btn_release, btn_long
  );

  // Conditioner side.
  modport slave (
    input  a_raw, b_raw, sw_raw,
    output a_clean, b_clean, btn_pressed, btn_press, btn_release, btn_long
  );

endinterface

// File: rtl/encoder_input_conditioner_debounce_channel.sv
// One pin channel: 2-FF synchroniser followed by a stable-count debouncer.
module debounce_channel #(
  parameter logic IDLE   = 1'b1,
  parameter int   CYCLES = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // cnt only ever reaches CYCLES-1 before being cleared, so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
      cnt   <= '0;
      dout  <= IDLE;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_input_conditioner.sv
// KY-040 pin conditioner: debounced A/B levels plus button level and event pulses.
// Optional long-press detection is built only when ENCODER_LONG_PRESS_EN is defined.
module encoder_input_conditioner
  import encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = ENC_DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_PRESS_CYCLES = 25_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  encoder_input_conditioner_if.slave    pins
);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_params
    $error("encoder_input_conditioner: cycle parameters must be >= 2");
  end

  logic         a_clean;
  logic         b_clean;
  logic         sw_clean;
  logic         sw_prev;
  logic         btn_pressed;
  enc_btn_evt_t evt_q;

  debounce_channel #(.IDLE(ENC_PIN_IDLE), .CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset(reset), .din(pins.a_raw), .dout(a_clean)
  );

  debounce_channel #(.IDLE(ENC_PIN_IDLE), .CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset(reset), .din(pins.b_raw), .dout(b_clean)
  );

  debounce_channel #(.IDLE(ENC_PIN_IDLE), .CYCLES(DEBOUNCE_CYCLES)) u_deb_sw (
    .clk(clk), .reset(reset), .din(pins.sw_raw), .dout(sw_clean)
  );

  // Button is active-low at the pin.
  assign btn_pressed = ~sw_clean;

`ifdef ENCODER_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_prev <= ENC_PIN_IDLE;
      evt_q   <= '0;
`ifdef ENCODER_LONG_PRESS_EN
      hold_cnt <= '0;
`endif
    end else begin
      sw_prev          <= sw_clean;
      evt_q.press      <= sw_prev & ~sw_clean;
      evt_q.release_ev <= ~sw_prev & sw_clean;
`ifdef ENCODER_LONG_PRESS_EN
      // Saturating at LONG_PRESS_CYCLES keeps the fire compare true for one cycle per press.
      evt_q.long_press <= btn_pressed && (hold_cnt == HOLD_FIRE);
      if (!btn_pressed) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
`else
      evt_q.long_press <= 1'b0;
`endif
    end
  end

  assign pins.a_clean     = a_clean;
  assign pins.b_clean     = b_clean;
  assign pins.btn_pressed = btn_pressed;
  assign pins.btn_press   = evt_q.press;
  assign pins.btn_release = evt_q.release_ev;
  assign pins.btn_long    = evt_q.long_press;

endmodule

// File: tb/tb_encoder_input_conditioner.sv
// Directed bench for encoder_input_conditioner with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
module tb_encoder_input_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int LAT  = DEB + 2;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  encoder_input_conditioner_if pins();

  encoder_input_conditioner #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pins (pins)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pins(input int cycles);
    pins.a_raw  = 1'b1;
    pins.b_raw  = 1'b1;
    pins.sw_raw = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic test_reset();
    pins.a_raw  = 1'b1;
    pins.b_raw  = 1'b1;
    pins.sw_raw = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) reset = 1'b1;
      tick();
      n_vec++;
      if ({pins.a_clean, pins.b_clean} !== 2'b11) begin
        n_err++;
        $display("FAIL reset_clean cyc=%0d got=%b exp=11", i, {pins.a_clean, pins.b_clean});
      end
      n_vec++;
      if ({pins.btn_pressed, pins.btn_press, pins.btn_release, pins.btn_long} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_btn cyc=%0d got=%b exp=0000", i,
                 {pins.btn_pressed, pins.btn_press, pins.btn_release, pins.btn_long});
      end
    end
  endtask

  task automatic test_a_edge();
    logic exp_a;
    pins.a_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_a = (k >= LAT) ? 1'b0 : 1'b1;
      n_vec++;
      if (pins.a_clean !== exp_a) begin
        n_err++;
        $display("FAIL a_fall k=%0d got=%b exp=%b", k, pins.a_clean, exp_a);
      end
      n_vec++;
      if (pins.b_clean !== 1'b1) begin
        n_err++;
        $display("FAIL b_idle k=%0d got=%b exp=1", k, pins.b_clean);
      end
    end
    pins.a_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_a = (k >= LAT) ? 1'b1 : 1'b0;
      n_vec++;
      if (pins.a_clean !== exp_a) begin
        n_err++;
        $display("FAIL a_rise k=%0d got=%b exp=%b", k, pins.a_clean, exp_a);
      end
    end
  endtask

  task automatic test_glitch();
    pins.a_raw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) pins.a_raw = 1'b1;
      n_vec++;
      if (pins.a_clean !== 1'b1) begin
        n_err++;
        $display("FAIL a_glitch k=%0d got=%b exp=1", k, pins.a_clean);
      end
    end
  endtask

  task automatic test_ab_simultaneous();
    logic [1:0] exp_ab;
    pins.a_raw = 1'b0;
    pins.b_raw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 2) pins.b_raw = 1'b1;
      // B bounces back after 2 cycles and must stay idle; A holds low.
      exp_ab = (k >= LAT) ? 2'b01 : 2'b11;
      n_vec++;
      if ({pins.a_clean, pins.b_clean} !== exp_ab) begin
        n_err++;
        $display("FAIL ab_indep k=%0d got=%b exp=%b", k, {pins.a_clean, pins.b_clean}, exp_ab);
      end
    end
    pins.a_raw = 1'b1;
  endtask

  task automatic test_button();
    logic [3:0] exp_btn;
    logic [3:0] got_btn;
    int presses, releases, longs;
    presses = 0;
    releases = 0;
    longs = 0;
    pins.sw_raw = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k == 20) pins.sw_raw = 1'b1;
      exp_btn[3] = (k >= LAT) && (k < 20 + LAT);
      exp_btn[2] = (k == LAT + 1);
      exp_btn[1] = (k == 20 + LAT + 1);
`ifdef ENCODER_LONG_PRESS_EN
      exp_btn[0] = (k == LAT + LONG);
`else
      exp_btn[0] = 1'b0;
`endif
      got_btn = {pins.btn_pressed, pins.btn_press, pins.btn_release, pins.btn_long};
      presses  += int'(pins.btn_press === 1'b1);
      releases += int'(pins.btn_release === 1'b1);
      longs    += int'(pins.btn_long === 1'b1);
      n_vec++;
      if (got_btn !== exp_btn) begin
        n_err++;
        $display("FAIL btn_seq k=%0d got=%b exp=%b (pressed,press,release,long)", k, got_btn, exp_btn);
      end
    end
    n_vec++;
    if (presses != 1 || releases != 1) begin
      n_err++;
      $display("FAIL btn_counts got press=%0d release=%0d exp=1,1", presses, releases);
    end
    n_vec++;
`ifdef ENCODER_LONG_PRESS_EN
    if (longs != 1) begin
      n_err++;
      $display("FAIL btn_long_count got=%0d exp=1", longs);
    end
`else
    if (longs != 0) begin
      n_err++;
      $display("FAIL btn_long_count got=%0d exp=0", longs);
    end
`endif
  endtask

  task automatic test_reset_mid_count();
    logic exp_a;
    pins.a_raw = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b0;
    tick();
    tick();
    n_vec++;
    if (pins.a_clean !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_hold got=%b exp=1", pins.a_clean);
    end
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_a = (k >= LAT) ? 1'b0 : 1'b1;
      n_vec++;
      if (pins.a_clean !== exp_a) begin
        n_err++;
        $display("FAIL rst_mid_recount k=%0d got=%b exp=%b", k, pins.a_clean, exp_a);
      end
    end
    pins.a_raw = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    pins.a_raw  = 1'b1;
    pins.b_raw  = 1'b1;
    pins.sw_raw = 1'b1;
    test_reset();
    idle_pins(4);
    test_a_edge();
    idle_pins(10);
    test_glitch();
    idle_pins(10);
    test_ab_simultaneous();
    idle_pins(10);
    test_button();
    idle_pins(10);
    test_reset_mid_count();
    idle_pins(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
